// File: rtl/lock_pkg.sv
// Shared definitions for the keypad path: key bus encoding and the
// supervisor state encoding.
package lock_pkg;

  localparam int unsigned KEY_WIDTH = 4;
  localparam logic [KEY_WIDTH-1:0] KEY_NONE = 4'h0;

  typedef enum logic [1:0] {
    StMonitor = 2'd0,
    StLockout = 2'd1,
    StRelease = 2'd2
  } sup_state_e;

endpackage

// File: rtl/lock_attempt_supervisor_edge_detect.sv
// Registered edge detector: rising-edge or any-edge pulse, with an optional
// mask until the first sample after reset has been taken.
module edge_detect #(
  parameter bit ANY_EDGE   = 1'b0,
  parameter bit MASK_FIRST = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;
  logic primed_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q    <= 1'b0;
      primed_q <= ~MASK_FIRST;
    end else begin
      sig_q    <= sig;
      primed_q <= 1'b1;
    end
  end

  // Until primed, sig_q holds the reset value rather than a real sample.
  assign pulse = primed_q & (ANY_EDGE ? (sig ^ sig_q) : (sig & ~sig_q));

endmodule

// File: rtl/lock_attempt_supervisor.sv
// Gates keypad input into the digital lock and enforces escalating lockouts
// after repeated failed code entries.
module lock_attempt_supervisor
  import lock_pkg::*;
#(
  parameter int unsigned     CLOCK_FREQ    = 50000000,
  parameter int unsigned     MAX_FAILS     = 3,
  parameter longint unsigned LOCKOUT_BASE  = 64'(30) * CLOCK_FREQ,
  parameter int unsigned     MAX_LEVEL     = 3,
  parameter int unsigned     FAIL_WIDTH    = $clog2(MAX_FAILS + 1),
  parameter int unsigned     LEVEL_WIDTH   = $clog2(MAX_LEVEL + 1),
  parameter int unsigned     LOCKOUT_WIDTH = $clog2((LOCKOUT_BASE << MAX_LEVEL) + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic                   lock_locked,
  input  logic                   lock_error,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic                   lockout,
  output logic [FAIL_WIDTH-1:0]  fail_count,
  output logic [LEVEL_WIDTH-1:0] level
);

  localparam logic [FAIL_WIDTH-1:0]    FAIL_LAST = FAIL_WIDTH'(MAX_FAILS - 1);
  localparam logic [LEVEL_WIDTH-1:0]   LEVEL_TOP = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LOCKOUT_WIDTH-1:0] BASE_W    = LOCKOUT_WIDTH'(LOCKOUT_BASE);
  localparam logic [LOCKOUT_WIDTH-1:0] CNT_ONE   = LOCKOUT_WIDTH'(1);

  sup_state_e               state_q;
  logic [FAIL_WIDTH-1:0]    fail_q;
  logic [LEVEL_WIDTH-1:0]   level_q;
  logic [LOCKOUT_WIDTH-1:0] cnt_q;
  logic                     fail_evt;
  logic                     ok_evt;

  edge_detect #(
    .ANY_EDGE   (1'b0),
    .MASK_FIRST (1'b0)
  ) u_error_edge (
    .clock (clock),
    .reset (reset),
    .sig   (lock_error),
    .pulse (fail_evt)
  );

  // locked_q only becomes meaningful after its first sample post-reset.
  edge_detect #(
    .ANY_EDGE   (1'b1),
    .MASK_FIRST (1'b1)
  ) u_locked_edge (
    .clock (clock),
    .reset (reset),
    .sig   (lock_locked),
    .pulse (ok_evt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StMonitor;
      fail_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StMonitor: begin
          if (ok_evt) begin
            fail_q  <= '0;
            level_q <= '0;
          end else if (fail_evt) begin
            if (fail_q == FAIL_LAST) begin
              fail_q  <= '0;
              cnt_q   <= BASE_W << level_q;
              level_q <= (level_q < LEVEL_TOP) ? level_q + LEVEL_WIDTH'(1) : LEVEL_TOP;
              state_q <= StLockout;
            end else begin
              fail_q <= fail_q + FAIL_WIDTH'(1);
            end
          end
        end
        StLockout: begin
          // A successful entry forgives escalation but never shortens this lockout.
          if (ok_evt) level_q <= '0;
          if (cnt_q == CNT_ONE) begin
            cnt_q   <= '0;
            state_q <= StRelease;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        StRelease: begin
          if (ok_evt) level_q <= '0;
          if (key_in == KEY_NONE) state_q <= StMonitor;
        end
        default: begin
          state_q <= StMonitor;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_out    = (state_q == StMonitor) ? key_in : KEY_NONE;
  assign lockout    = (state_q != StMonitor);
  assign fail_count = fail_q;
  assign level      = level_q;

endmodule

// File: tb/tb_lock_attempt_supervisor.sv
// Directed self-checking bench for lock_attempt_supervisor with a short
// lockout base so every escalation level is exercised.
module tb_lock_attempt_supervisor;

  localparam int unsigned BASE = 10;

  logic       clock;
  logic       reset;
  logic [3:0] key_in;
  logic       lock_locked;
  logic       lock_error;
  logic [3:0] key_out;
  logic       lockout;
  logic [1:0] fail_count;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  lock_attempt_supervisor #(
    .CLOCK_FREQ   (1000),
    .MAX_FAILS    (3),
    .LOCKOUT_BASE (64'(BASE)),
    .MAX_LEVEL    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_in      (key_in),
    .lock_locked (lock_locked),
    .lock_error  (lock_error),
    .key_out     (key_out),
    .lockout     (lockout),
    .fail_count  (fail_count),
    .level       (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Single-cycle high on lock_error, then low for gap cycles.
  task automatic fail_pulse(input int gap);
    lock_error = 1'b1;
    tick();
    lock_error = 1'b0;
    tick(gap);
  endtask

  // Count samples with lockout high (LOCKOUT plus one RELEASE cycle when key_in=0).
  task automatic measure_lockout(output int n);
    n = 0;
    while (lockout && n < 500) begin
      n++;
      tick();
    end
  endtask

  task automatic run_lockout(input int exp_len, input int exp_level, input string tag);
    int n;
    fail_pulse(4);
    check_eq({tag, "_fail1"}, fail_count, 1);
    fail_pulse(4);
    check_eq({tag, "_fail2"}, fail_count, 2);
    check_eq({tag, "_pre_lockout"}, lockout, 0);
    lock_error = 1'b1;
    tick();
    lock_error = 1'b0;
    check_eq({tag, "_lockout_on"}, lockout, 1);
    check_eq({tag, "_key_blocked"}, key_out, 0);
    check_eq({tag, "_fail_clr"}, fail_count, 0);
    check_eq({tag, "_level"}, level, exp_level);
    measure_lockout(n);
    check_eq({tag, "_len"}, n, exp_len + 1);
  endtask

  initial begin
    reset       = 1'b1;
    key_in      = 4'h0;
    lock_locked = 1'b0;
    lock_error  = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();

    // Reset state and zero-latency passthrough
    key_in = 4'h5;
    #1;
    check_eq("rst_key_out", key_out, 5);
    check_eq("rst_lockout", lockout, 0);
    check_eq("rst_fail", fail_count, 0);
    check_eq("rst_level", level, 0);
    key_in = 4'h0;
    tick();

    // Escalating lockouts, saturating at level 2
    run_lockout(BASE,     1, "lo1");
    check_eq("lo1_monitor", lockout, 0);
    run_lockout(BASE * 2, 2, "lo2");
    run_lockout(BASE * 4, 2, "lo3");
    run_lockout(BASE * 4, 2, "lo4");

    // Key held across the end of lockout stays blocked until released
    fail_pulse(4);
    fail_pulse(4);
    lock_error = 1'b1;
    tick();
    lock_error = 1'b0;
    key_in = 4'h3;
    tick(BASE * 4 + 10);
    check_eq("hold_lockout", lockout, 1);
    check_eq("hold_key_out", key_out, 0);
    key_in = 4'h0;
    #1;
    check_eq("hold_release_still", lockout, 1);
    tick();
    check_eq("hold_monitor", lockout, 0);
    key_in = 4'h3;
    #1;
    check_eq("hold_pass", key_out, 3);
    key_in = 4'h0;
    tick();

    // Successful entry clears counts; ok wins over a simultaneous fail
    fail_pulse(2);
    fail_pulse(2);
    check_eq("ok_pre_fail", fail_count, 2);
    check_eq("ok_pre_level", level, 2);
    lock_locked = 1'b1;
    tick();
    check_eq("ok_fail_clr", fail_count, 0);
    check_eq("ok_level_clr", level, 0);
    lock_locked = 1'b0;
    lock_error  = 1'b1;
    tick();
    check_eq("ok_prio_fail", fail_count, 0);
    lock_error = 1'b0;
    tick(2);

    // ok during lockout clears level but keeps lockout; then reset mid-lockout
    fail_pulse(2);
    fail_pulse(2);
    lock_error = 1'b1;
    tick();
    lock_error = 1'b0;
    check_eq("mid_level", level, 1);
    lock_locked = 1'b1;
    tick();
    check_eq("mid_ok_level", level, 0);
    check_eq("mid_ok_lockout", lockout, 1);
    tick(2);
    reset  = 1'b1;
    key_in = 4'h7;
    #1;
    check_eq("mid_rst_lockout", lockout, 0);
    check_eq("mid_rst_fail", fail_count, 0);
    check_eq("mid_rst_level", level, 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_key", key_out, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
